// File: rtl/qfilt_pkg.sv
// Shared definitions for the queue mask filter.
// Holds the fully-filtered sub-queue policy enum used by the filter and its keep selector.
package qfilt_pkg;

    typedef enum logic {
        EMPTY_DROP = 1'b0,
        EMPTY_EMIT = 1'b1
    } empty_mode_e;

endpackage

// File: rtl/qfilt_mask_sel.sv
// Keep/match decision for one incoming item against the active ctrl mask.
// Unmatched sub-queue terminators are kept as zero-data stand-in items only when no item of that sub-queue matched.
module qfilt_mask_sel
    import qfilt_pkg::*;
#(
    parameter int          W_CTRL     = 1,
    parameter empty_mode_e EMPTY_MODE = EMPTY_DROP
) (
    input  logic [(2**W_CTRL)-1:0] mask_reg,
    input  logic [W_CTRL-1:0]      ctrl,
    input  logic                   eot0,
    input  logic                   seen_match,
    output logic                   match,
    output logic                   keep
);

    // Mask lookup and empty sub-queue stand-in qualification.
    always_comb begin
        match = mask_reg[ctrl];
        keep  = 1'b0;
        if (match) begin
            keep = 1'b1;
        end else if (EMPTY_MODE == EMPTY_EMIT) begin
            keep = eot0 && !seen_match;
        end else begin
            keep = 1'b0;
        end
    end

endmodule

// File: rtl/qfilt_mask.sv
// Queue filter: forwards items whose ctrl value is enabled in a runtime mask and
// folds the eot bits of dropped items into the last kept item held in a one-slot buffer.
module qfilt_mask
    import qfilt_pkg::*;
#(
    parameter int                      W_DIN      = 16,
    parameter int                      W_DOUT     = 16,
    parameter int                      W_CTRL     = 1,
    parameter int                      LVL        = 1,
    parameter empty_mode_e             EMPTY_MODE = EMPTY_DROP,
    parameter logic [(2**W_CTRL)-1:0]  MASK_RST   = {{((2**W_CTRL)-1){1'b0}}, 1'b1}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic [(2**W_CTRL)-1:0]       sel_data,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [LVL+W_CTRL+W_DIN-1:0]  din_data,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [LVL+W_DOUT-1:0]        dout_data
);

    localparam int W_MASK = 2**W_CTRL;

    typedef struct packed {
        logic [LVL-1:0]    eot;
        logic [W_CTRL-1:0] ctrl;
        logic [W_DIN-1:0]  data;
    } din_t;

    typedef struct packed {
        logic [LVL-1:0]    eot;
        logic [W_DOUT-1:0] data;
    } dout_t;

    din_t              din_s;
    dout_t             dout_s;

    logic              hold_valid_r;
    logic [LVL-1:0]    hold_eot_r;
    logic [W_DOUT-1:0] hold_data_r;
    logic              in_queue_r;
    logic              seen_match_r;
    logic [W_MASK-1:0] mask_r;

    logic              hold_valid_nxt_s;
    logic [LVL-1:0]    hold_eot_nxt_s;
    logic [W_DOUT-1:0] hold_data_nxt_s;
    logic              in_queue_nxt_s;
    logic              seen_match_nxt_s;
    logic [W_MASK-1:0] mask_nxt_s;

    logic              match_s;
    logic              keep_s;
    logic              sel_block_s;
    logic              dout_valid_s;
    logic              handshake_s;
    logic              din_ready_s;
    logic              accept_s;
    logic              sel_accept_s;

    assign din_s = din_t'(din_data);

    qfilt_mask_sel #(
        .W_CTRL     (W_CTRL),
        .EMPTY_MODE (EMPTY_MODE)
    ) u_sel (
        .mask_reg   (mask_r),
        .ctrl       (din_s.ctrl),
        .eot0       (din_s.eot[0]),
        .seen_match (seen_match_r),
        .match      (match_s),
        .keep       (keep_s)
    );

    // Handshake arbitration; a pending mask update between outer queues stalls din.
    always_comb begin
        sel_block_s  = sel_valid && !in_queue_r;
        sel_accept_s = sel_valid && !in_queue_r;
        dout_valid_s = hold_valid_r &&
                       ((din_valid && keep_s && !sel_block_s) || hold_eot_r[LVL-1]);
        handshake_s  = dout_valid_s && dout_ready;
        din_ready_s  = 1'b0;
        if (!din_valid || sel_block_s) begin
            din_ready_s = 1'b0;
        end else if (keep_s) begin
            din_ready_s = !hold_valid_r || handshake_s;
        end else begin
            din_ready_s = !dout_valid_s || handshake_s;
        end
        accept_s = din_valid && din_ready_s;
    end

    // Hold-slot update: load a kept item, drain on handshake, or merge a dropped item's eot.
    always_comb begin
        hold_valid_nxt_s = hold_valid_r;
        hold_eot_nxt_s   = hold_eot_r;
        hold_data_nxt_s  = hold_data_r;
        if (accept_s && keep_s) begin
            hold_valid_nxt_s = 1'b1;
            hold_eot_nxt_s   = din_s.eot;
            if (match_s) begin
                hold_data_nxt_s = din_s.data[W_DOUT-1:0];
            end else begin
                hold_data_nxt_s = {W_DOUT{1'b0}};
            end
        end else if (handshake_s) begin
            hold_valid_nxt_s = 1'b0;
            hold_eot_nxt_s   = {LVL{1'b0}};
            hold_data_nxt_s  = {W_DOUT{1'b0}};
        end else if (accept_s && hold_valid_r) begin
            hold_eot_nxt_s = hold_eot_r | din_s.eot;
        end else begin
            hold_eot_nxt_s = hold_eot_r;
        end
    end

    // Queue-position tracking and mask reload.
    always_comb begin
        in_queue_nxt_s   = in_queue_r;
        seen_match_nxt_s = seen_match_r;
        mask_nxt_s       = mask_r;
        if (accept_s) begin
            in_queue_nxt_s = !din_s.eot[LVL-1];
        end else begin
            in_queue_nxt_s = in_queue_r;
        end
        if (accept_s && din_s.eot[0]) begin
            seen_match_nxt_s = 1'b0;
        end else if (accept_s && match_s) begin
            seen_match_nxt_s = 1'b1;
        end else begin
            seen_match_nxt_s = seen_match_r;
        end
        if (sel_accept_s) begin
            mask_nxt_s = sel_data;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_eot_r   <= {LVL{1'b0}};
            hold_data_r  <= {W_DOUT{1'b0}};
            in_queue_r   <= 1'b0;
            seen_match_r <= 1'b0;
            mask_r       <= MASK_RST;
        end else begin
            hold_valid_r <= hold_valid_nxt_s;
            hold_eot_r   <= hold_eot_nxt_s;
            hold_data_r  <= hold_data_nxt_s;
            in_queue_r   <= in_queue_nxt_s;
            seen_match_r <= seen_match_nxt_s;
            mask_r       <= mask_nxt_s;
        end
    end

    assign dout_s     = '{eot: hold_eot_r, data: hold_data_r};
    assign dout_data  = dout_s;
    assign dout_valid = dout_valid_s;
    assign din_ready  = din_ready_s;
    assign sel_ready  = !in_queue_r;

endmodule
